regfile_mp: RTL and testbench

//  Multi-port integer register file for the LemonPC core. It is the parametrised successor of the

---
 rtl/regfile_mp.sv | 155 +++++++++++++++
 tb/tb_regfile_mp.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port integer register file: NR_RD combinational reads, two writeback ports,
// optional write-to-read bypass, hardwired zero register, busy scoreboard and post-reset clear.
module regfile_mp #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NR_RD      = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NR_RD*ADDR_WIDTH-1:0]   raddr,
  output logic [NR_RD*DATA_WIDTH-1:0]   rdata,
  output logic [NR_RD-1:0]              rd_busy,
  input  logic                          wen0,
  input  logic [ADDR_WIDTH-1:0]         waddr0,
  input  logic [DATA_WIDTH-1:0]         wdata0,
  input  logic                          wen1,
  input  logic [ADDR_WIDTH-1:0]         waddr1,
  input  logic [DATA_WIDTH-1:0]         wdata1,
  input  logic                          issue_en,
  input  logic [ADDR_WIDTH-1:0]         issue_rd,
  output logic                          init_done
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                  state_reg;
  state_t                  state_next;
  logic [ADDR_WIDTH-1:0]   clr_cnt_reg;
  logic                    clr_last;
  logic                    ready;
  logic                    clr_en;

  logic [DATA_WIDTH-1:0]   rf_reg [DEPTH];
  logic [DEPTH-1:0]        busy_reg;
  logic [DEPTH-1:0]        busy_next;

  logic                    w0_ok;
  logic                    w1_ok;
  logic                    iss_ok;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= INIT;
    end else begin
      state_reg <= state_next;
    end
  end

  assign clr_last = (clr_cnt_reg == '1);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      INIT:    if (clr_last) state_next = READY;
      READY:   state_next = READY;
      default: state_next = INIT;
    endcase
  end

  always_comb begin
    ready     = 1'b0;
    clr_en    = 1'b0;
    init_done = 1'b0;
    case (state_reg)
      INIT:    clr_en = 1'b1;
      READY: begin
        ready     = 1'b1;
        init_done = 1'b1;
      end
      default: clr_en = 1'b1;
    endcase
  end

  // Clear pointer wraps back to 0 on the last entry, ready for the next reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_cnt_reg <= '0;
    end else if (clr_en) begin
      clr_cnt_reg <= clr_cnt_reg + ADDR_WIDTH'(1);
    end
  end

  // ------------------------------------------------------ write qualifiers
  assign w0_ok  = ready && wen0     && !((ZERO_REG != 0) && (waddr0   == '0));
  assign w1_ok  = ready && wen1     && !((ZERO_REG != 0) && (waddr1   == '0));
  assign iss_ok = ready && issue_en && !((ZERO_REG != 0) && (issue_rd == '0));

  // Port 1 is written last so it wins on an index collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_en) rf_reg[clr_cnt_reg] <= '0;
      if (w0_ok)  rf_reg[waddr0]      <= wdata0;
      if (w1_ok)  rf_reg[waddr1]      <= wdata1;
    end
  end

  // ------------------------------------------------------------ scoreboard
  // Issue is applied after the clears: a newer producer keeps the entry busy.
  always_comb begin
    busy_next = busy_reg;
    if (w0_ok)  busy_next[waddr0]   = 1'b0;
    if (w1_ok)  busy_next[waddr1]   = 1'b0;
    if (iss_ok) busy_next[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  // ------------------------------------------------------------ read ports
  for (genvar gi = 0; gi < NR_RD; gi++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic                  zero_hit;
    logic                  hit0;
    logic                  hit1;
    logic [DATA_WIDTH-1:0] data_port;
    logic                  busy_port;

    assign ra       = raddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign zero_hit = (ZERO_REG != 0) && (ra == '0);
    assign hit1     = (BYPASS != 0) && wen1 && (waddr1 == ra);
    assign hit0     = (BYPASS != 0) && wen0 && (waddr0 == ra);

    always_comb begin
      data_port = rf_reg[ra];
      busy_port = busy_reg[ra];
      if (!ready || zero_hit) begin
        data_port = '0;
        busy_port = 1'b0;
      end else if (hit1) begin
        data_port = wdata1;
        busy_port = 1'b0;
      end else if (hit0) begin
        data_port = wdata0;
        busy_port = 1'b0;
      end
    end

    assign rdata[gi*DATA_WIDTH +: DATA_WIDTH] = data_port;
    assign rd_busy[gi]                        = busy_port;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: expectations are queued when stimulus is driven and
// popped by immediate assertions when the corresponding output is sampled.
module tb_regfile_mp;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR*AW-1:0]  raddr;
  logic [NR*DW-1:0]  rdata;
  logic [NR-1:0]     rd_busy;
  logic              wen0;
  logic [AW-1:0]     waddr0;
  logic [DW-1:0]     wdata0;
  logic              wen1;
  logic [AW-1:0]     waddr1;
  logic [DW-1:0]     wdata1;
  logic              issue_en;
  logic [AW-1:0]     issue_rd;
  logic              init_done;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  regfile_mp #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR_RD(NR), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rd_busy(rd_busy),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .issue_en(issue_en), .issue_rd(issue_rd), .init_done(init_done)
  );

  task automatic push_exp(input string tag, input logic [31:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic check(input logic [31:0] obs);
    logic [31:0] e;
    string       t;
    n_assert++;
    assert (exp_q.size() != 0) else begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %h required a queued expectation", obs);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      $display("check %s: observed %h expected %h", t, obs, e);
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", t, obs, e);
      end
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init(output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!init_done && n < 100);
  endtask

  initial begin
    rst = 1'b1; raddr = '0; wen0 = 1'b0; waddr0 = '0; wdata0 = '0;
    wen1 = 1'b0; waddr1 = '0; wdata1 = '0; issue_en = 1'b0; issue_rd = '0;

    // 1. reset, clear sequence, writes/issues ignored during INIT
    raddr[4:0] = 5'd5;
    next_cycle();
    @(negedge clk);
    push_exp("rst_init_done", 32'd0); check(32'(init_done));
    push_exp("rst_rdata",     32'd0); check(rdata[31:0]);
    push_exp("rst_rd_busy",   32'd0); check(32'(rd_busy));
    rst = 1'b0;
    wen0 = 1'b1; waddr0 = 5'd1; wdata0 = 32'h55; issue_en = 1'b1; issue_rd = 5'd2;
    raddr = {5'd2, 5'd1};
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == 16) begin
        push_exp("init_rd_bypass", 32'd0); check(rdata[31:0]);
        push_exp("init_rd_busy",   32'd0); check(32'(rd_busy[1]));
      end
    end while (!init_done && cyc < 100);
    wen0 = 1'b0; issue_en = 1'b0;
    push_exp("init_cycles", 32'd32); check(32'(cyc));

    for (int i = 0; i < 32; i++) begin
      next_cycle();
      raddr = {5'(31 - i), 5'(i)};
      @(negedge clk);
      push_exp($sformatf("clear_rd0_x%0d", i), 32'd0);      check(rdata[31:0]);
      push_exp($sformatf("clear_rd1_x%0d", 31 - i), 32'd0); check(rdata[63:32]);
      push_exp($sformatf("clear_busy_%0d", i), 32'd0);      check(32'(rd_busy));
    end

    // 2. write + bypass
    next_cycle();
    wen0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF; raddr = {5'd6, 5'd5};
    push_exp("bypass_x5", 32'hDEADBEEF);
    @(negedge clk); check(rdata[31:0]);
    next_cycle();
    wen0 = 1'b0;
    push_exp("stored_x5", 32'hDEADBEEF);
    @(negedge clk); check(rdata[31:0]);

    // 3. dual write, same index and different indices
    next_cycle();
    wen0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h1;
    wen1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h2;
    raddr = {5'd6, 5'd7};
    push_exp("same_idx_bypass", 32'h2);
    @(negedge clk); check(rdata[31:0]);
    next_cycle();
    waddr0 = 5'd3; wdata0 = 32'hA; waddr1 = 5'd4; wdata1 = 32'hB;
    push_exp("same_idx_stored", 32'h2);
    @(negedge clk); check(rdata[31:0]);
    next_cycle();
    wen0 = 1'b0; wen1 = 1'b0; raddr = {5'd4, 5'd3};
    push_exp("dual_x3", 32'hA);
    push_exp("dual_x4", 32'hB);
    @(negedge clk); check(rdata[31:0]); check(rdata[63:32]);

    // 4. zero register
    next_cycle();
    wen1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFF_FFFF; issue_en = 1'b1; issue_rd = 5'd0;
    raddr = {5'd3, 5'd0};
    push_exp("zero_write_cycle", 32'd0);
    push_exp("zero_busy_cycle",  32'd0);
    @(negedge clk); check(rdata[31:0]); check(32'(rd_busy[0]));
    next_cycle();
    wen1 = 1'b0; issue_en = 1'b0;
    push_exp("zero_after",      32'd0);
    push_exp("zero_busy_after", 32'd0);
    @(negedge clk); check(rdata[31:0]); check(32'(rd_busy[0]));

    // 5. scoreboard
    next_cycle();
    issue_en = 1'b1; issue_rd = 5'd9; raddr = {5'd3, 5'd9};
    push_exp("busy_before_issue", 32'd0);
    @(negedge clk); check(32'(rd_busy[0]));
    next_cycle();
    issue_en = 1'b0;
    push_exp("busy_set", 32'd1);
    @(negedge clk); check(32'(rd_busy[0]));
    next_cycle();
    wen0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h99;
    push_exp("busy_bypass",      32'd0);
    push_exp("busy_bypass_data", 32'h99);
    @(negedge clk); check(32'(rd_busy[0])); check(rdata[31:0]);
    next_cycle();
    wen0 = 1'b0;
    push_exp("busy_cleared", 32'd0);
    @(negedge clk); check(32'(rd_busy[0]));
    next_cycle();
    issue_en = 1'b1; issue_rd = 5'd9; wen1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h1234;
    push_exp("busy_race_bypass", 32'd0);
    @(negedge clk); check(32'(rd_busy[0]));
    next_cycle();
    issue_en = 1'b0; wen1 = 1'b0;
    push_exp("busy_set_wins", 32'd1);
    push_exp("race_data",     32'h1234);
    @(negedge clk); check(32'(rd_busy[0])); check(rdata[31:0]);

    // 6. reset reasserted mid-clear
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    push_exp("rst2_init_done", 32'd0);
    @(negedge clk); check(32'(init_done));
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    push_exp("mid_init_done", 32'd0);
    @(negedge clk); check(32'(init_done));
    next_cycle();
    rst = 1'b0;
    wait_init(cyc);
    push_exp("restart_cycles",    32'd32);
    push_exp("busy_after_rst",    32'd0);
    push_exp("cleared_after_rst", 32'd0);
    check(32'(cyc)); check(32'(rd_busy[0])); check(rdata[31:0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
